f_pc_seq: RTL and testbench

F_PC_SEQ -- requirements
Module: f_pc_seq

---
 rtl/f_pc_seq_if.sv | 29 ++
 rtl/f_pc_seq.sv | 69 ++++++
 tb/tb_f_pc_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/f_pc_seq_if.sv
// Fetch-PC sequencer bundle: redirect/stall controls from D stage and CP0 in, fetch address and status out.
// The sequencer owns the slave side; whoever drives the controls holds the master side.
interface f_pc_seq_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic        bd_f;
    logic        adel_f;
    logic        f_valid;

    modport master (
        output stall, npc_sel, br_taken, br_target, j_target, jr_target,
        output exc_req, eret, epc,
        input  pc_f, bd_f, adel_f, f_valid
    );

    modport slave (
        input  stall, npc_sel, br_taken, br_target, j_target, jr_target,
        input  exc_req, eret, epc,
        output pc_f, bd_f, adel_f, f_valid
    );
endinterface

// File: rtl/f_pc_seq.sv
// F-stage PC register: next PC picked by exc_req > eret > stall > npc_sel and loaded on the same edge.
// stall freezes pc_f, bd_f and state; exception entry and eret override stall.
module f_pc_seq (
    input  logic     clk,
    input  logic     reset,
    f_pc_seq_if.slave bus
);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

    typedef enum logic {RUN, REDIR} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] pc_seq;
    logic        bd_q;
    logic        bd_nxt;
    logic        started;

    assign pc_seq = pc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            bd_q    <= 1'b0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            bd_q    <= bd_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        bd_nxt    = bd_q;
        if (bus.exc_req) begin
            state_nxt = REDIR;
            pc_nxt    = EXC_VEC;
            bd_nxt    = 1'b0;
        end else if (bus.eret) begin
            state_nxt = REDIR;
            pc_nxt    = bus.epc;
            bd_nxt    = 1'b0;
        end else if (!bus.stall) begin
            state_nxt = RUN;
            bd_nxt    = (bus.npc_sel != 2'b00);
            case (bus.npc_sel)
                2'b00:   pc_nxt = pc_seq;
                2'b01:   pc_nxt = bus.br_taken ? bus.br_target : pc_seq;
                2'b10:   pc_nxt = bus.j_target;
                default: pc_nxt = bus.jr_target;
            endcase
        end
    end

    assign bus.pc_f    = pc_q;
    assign bus.bd_f    = bd_q;
    // Redirected fetches stay valid; only the cycle right after reset release is not.
    assign bus.f_valid = started;
    assign bus.adel_f  = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
endmodule

// File: tb/tb_f_pc_seq.sv
// Randomized scoreboard bench for f_pc_seq: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_f_pc_seq;
    logic clk;
    logic reset;

    f_pc_seq_if bus();

    f_pc_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_pc;
    logic        m_bd;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
        end else begin
            a = $urandom_range(32'h6FFC, 32'h3000);
            a = a & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) a = a | 32'h1;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        #1;
        if (!reset && sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp("pc_f",    bus.pc_f,                 mon_e.pc);
            cmp("bd_f",    32'(bus.bd_f),            32'(mon_e.bd));
            cmp("adel_f",  32'(bus.adel_f),          32'(ref_adel(mon_e.pc)));
            cmp("f_valid", 32'(bus.f_valid),         32'(mon_e.valid));
        end
    end

    // Called at a falling edge; pushes the state expected after the coming rising edge.
    task automatic step(input logic st, input logic [1:0] sel, input logic tk,
                        input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt,
                        input logic ex, input logic er, input logic [31:0] ep);
        exp_t e;
        bus.stall = st; bus.npc_sel = sel; bus.br_taken = tk;
        bus.br_target = bt; bus.j_target = jt; bus.jr_target = jrt;
        bus.exc_req = ex; bus.eret = er; bus.epc = ep;
        if (ex) begin
            m_pc = 32'h4180; m_bd = 1'b0;
        end else if (er) begin
            m_pc = ep; m_bd = 1'b0;
        end else if (!st) begin
            if (sel == 2'd0)      m_pc = m_pc + 32'd4;
            else if (sel == 2'd1) m_pc = tk ? bt : m_pc + 32'd4;
            else if (sel == 2'd2) m_pc = jt;
            else                  m_pc = jrt;
            m_bd = (sel != 2'd0);
        end
        e.pc = m_pc; e.bd = m_bd; e.valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic seq();
        step(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset pulse between edges; outputs must snap to reset values without a clock.
    task automatic reset_pulse();
        #1 reset = 1'b1;
        #1;
        cmp("rst_pc",    bus.pc_f,          32'h3000);
        cmp("rst_bd",    32'(bus.bd_f),     32'd0);
        cmp("rst_valid", 32'(bus.f_valid),  32'd0);
        reset = 1'b0;
        #1;
        cmp("rel_valid", 32'(bus.f_valid),  32'd0);
        cmp("rel_pc",    bus.pc_f,          32'h3000);
        m_pc = 32'h3000;
        m_bd = 1'b0;
    endtask

    initial begin
        logic ex, er, st, tk;
        logic [1:0] sel;
        int wait_cnt;
        reset = 1'b1;
        bus.stall = 1'b0; bus.npc_sel = 2'd0; bus.br_taken = 1'b0;
        bus.br_target = 32'h0; bus.j_target = 32'h0; bus.jr_target = 32'h0;
        bus.exc_req = 1'b0; bus.eret = 1'b0; bus.epc = 32'h0;
        m_pc = 32'h3000;
        m_bd = 1'b0;
        #1;
        cmp("init_pc",    bus.pc_f,         32'h3000);
        cmp("init_bd",    32'(bus.bd_f),    32'd0);
        cmp("init_valid", 32'(bus.f_valid), 32'd0);
        cmp("init_adel",  32'(bus.adel_f),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cmp("first_valid", 32'(bus.f_valid), 32'd0);

        seq(); seq(); seq(); seq();
        step(1'b0, 2'd1, 1'b1, 32'h3040, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h3010, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'd1, 1'b0, 32'h3040, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'd2, 1'b0, 32'h0, 32'h3100, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'd2, 1'b0, 32'h0, 32'h3100, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 2'd3, 1'b1, 32'h0, 32'h0, 32'h5000, 1'b1, 1'b1, 32'h3300);
        seq();
        step(1'b1, 2'd2, 1'b0, 32'h0, 32'h5000, 32'h0, 1'b0, 1'b1, 32'h3002);
        step(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h7000, 1'b0, 1'b0, 32'h0);
        step(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        seq();
        step(1'b0, 2'd2, 1'b0, 32'h0, 32'h3020, 32'h0, 1'b0, 1'b0, 32'h0);
        cmp("pre_rst_pc", bus.pc_f, 32'h3020);
        reset_pulse();
        seq();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse();
            ex  = ($urandom_range(0, 19) == 0);
            er  = ($urandom_range(0, 14) == 0);
            st  = ($urandom_range(0, 3) == 0);
            tk  = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            step(st, sel, tk, raddr(), raddr(), raddr(), ex, er, raddr());
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
